dcache_responder: RTL and testbench

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_pkg.sv | 42 ++++
 rtl/cache_line_array.sv | 63 ++++++
 rtl/dcache_responder.sv | 133 +++++++++++++
 tb/tb_dcache_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the dcache_responder slice.
//   Geometry : 8 lines x 4 words x 32 bits, 25-bit tag, 30-bit word address.
//   Types    : state_e (controller states), line_meta_t (valid/dirty/tag of
//              one line), proc_addr_t (tag/index/offset view of proc_addr).
//   Helper   : word_sel() picks one 32-bit word out of a 128-bit block.
package dcache_pkg;

    localparam int OFFSET_W   = 2;
    localparam int INDEX_W    = 3;
    localparam int TAG_W      = 25;
    localparam int LINES      = 8;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int WORDS      = BLOCK_W / WORD_W;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;   // 30
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;              // 28

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } proc_addr_t;

    // Word 0 of a block lives in bits [31:0].
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0]  blk,
                                                   input logic [OFFSET_W-1:0] off);
        return blk[WORD_W*int'(off) +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: tag/valid/dirty/data storage for the direct-mapped cache.
//   clk, rst     : clock, synchronous active-high reset (valid/dirty only;
//                  tag and data storage are never reset).
//   rd_index     : line selected for the combinational read port.
//   rd_meta      : valid/dirty/tag of the selected line.
//   rd_block     : 128-bit data of the selected line.
//   wr_*         : single-word write (CPU write hit); sets the dirty bit.
//   fill_*       : whole-line fill from memory; sets valid, clears dirty,
//                  loads the tag.
module cache_line_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    output line_meta_t          rd_meta,
    output logic [BLOCK_W-1:0]  rd_block,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic                fill_en,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_block
);

    logic [LINES-1:0]                   valid_q;
    logic [LINES-1:0]                   dirty_q;
    logic [TAG_W-1:0]                   tag_q  [LINES];
    logic [WORDS-1:0][WORD_W-1:0]       data_q [LINES];

    // Fill and word write come from different controller states, so they
    // never coincide; fill is listed first anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
            dirty_q[fill_index] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[fill_index] <= fill_block;
            tag_q[fill_index]  <= fill_tag;
        end else if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_word;
        end
    end

    always_comb begin
        rd_meta.valid = valid_q[rd_index];
        rd_meta.dirty = dirty_q[rd_index];
        rd_meta.tag   = tag_q[rd_index];
        rd_block      = data_q[rd_index];
    end

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache
// controller (8 lines x 4 words) between a CPU port and a block memory.
//   clk, rst            : clock, synchronous active-high reset.
//   proc_ren / proc_wen : CPU read / write request (write wins if both).
//   proc_addr           : word address {tag[29:5], index[4:2], offset[1:0]}.
//   proc_wdata          : write data, stored as-is.
//   proc_stall          : request not yet satisfied.
//   proc_rdata          : read data on a read hit, zero otherwise.
//   mem_read/mem_write  : block refill / victim writeback requests.
//   mem_addr            : block address {tag,index}.
//   mem_wdata/mem_rdata : victim / fill block, word 0 in [31:0].
//   mem_ready           : one-cycle completion pulse for the memory request.
// Optional: define DCACHE_PERF_CNT_EN to add saturating 32-bit hit_cnt and
// miss_cnt outputs.
module dcache_responder
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  proc_ren,
    input  logic                  proc_wen,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic                  proc_stall,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]    mem_wdata,
    input  logic [BLOCK_W-1:0]    mem_rdata,
    input  logic                  mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    state_e              state_q, state_d;
    proc_addr_t          req_addr;
    line_meta_t          meta;
    logic [BLOCK_W-1:0]  blk;
    logic                req, hit, idle_hit, idle_miss;
    logic                wr_en, fill_en;

    assign req_addr  = proc_addr;
    assign req       = proc_ren | proc_wen;
    assign hit       = meta.valid && (meta.tag == req_addr.tag);
    assign idle_hit  = (state_q == ST_IDLE) && req && hit;
    assign idle_miss = (state_q == ST_IDLE) && req && !hit;

    // Reset wins over everything, including a mem_ready arriving in the same
    // cycle: the in-flight refill is dropped rather than installed.
    assign wr_en   = idle_hit && proc_wen && !rst;
    assign fill_en = (state_q == ST_ALLOCATE) && mem_ready && !rst;

    cache_line_array u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (req_addr.index),
        .rd_meta    (meta),
        .rd_block   (blk),
        .wr_en      (wr_en),
        .wr_index   (req_addr.index),
        .wr_offset  (req_addr.offset),
        .wr_word    (proc_wdata),
        .fill_en    (fill_en),
        .fill_index (req_addr.index),
        .fill_tag   (req_addr.tag),
        .fill_block (mem_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state. After a fill the FSM returns to IDLE and the still-held
    // request is looked up again, completing as an ordinary hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_miss)
                    state_d = (meta.valid && meta.dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: if (mem_ready) state_d = ST_ALLOCATE;
            ST_ALLOCATE:  if (mem_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs. The request address is stable while stalled, so the victim
    // line is still the one indexed by proc_addr during WRITEBACK.
    always_comb begin
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = {req_addr.tag, req_addr.index};
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE: proc_stall = req && !hit;
            ST_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {meta.tag, req_addr.index};
                mem_wdata  = blk;
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
            end
            default: proc_stall = 1'b1;
        endcase
        proc_rdata = (idle_hit && !proc_wen) ? word_sel(blk, req_addr.offset) : '0;
    end

`ifdef DCACHE_PERF_CNT_EN
    // A miss is counted once, on the cycle IDLE decides to leave; the request
    // completing after the refill is counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + 32'd1;
            if (idle_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed scoreboard bench for dcache_responder. Stimulus pushes expected CPU
// completions and memory requests into queues; a negedge monitor pops and
// compares whenever the DUT completes a request or raises a memory request.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_ren, proc_wen;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    dcache_responder dut (
        .clk        (clk),
        .rst        (rst),
        .proc_ren   (proc_ren),
        .proc_wen   (proc_wen),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { bit is_rd; logic [31:0] rdata; } proc_exp_t;
    typedef struct { bit is_wr; logic [27:0] addr; logic [127:0] wdata; } mem_exp_t;
    proc_exp_t proc_q[$];
    mem_exp_t  mem_q[$];

    localparam logic [127:0] F0  = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    localparam logic [127:0] VIC = {32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF};
    localparam logic [127:0] F2  = {32'h44444444, 32'h99999999, 32'h88888888, 32'hCAFEF00D};
    localparam logic [127:0] F3  = {32'h77777777, 32'h66666666, 32'h55555555, 32'h0BADF00D};
    localparam logic [127:0] FX  = {4{32'hBAD0BAD0}};
    localparam logic [127:0] FY  = {32'h00000004, 32'h00000003, 32'h00000002, 32'h0000FACE};
    localparam logic [127:0] FP  = {32'h0000000C, 32'h0000000B, 32'h0000000A, 32'hFEEDC0DE};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitor ----------------
    proc_exp_t pe;
    mem_exp_t  me;
    logic      prev_mr = 1'b0, prev_mw = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read && mem_write) flag("mem_rd_wr_both_high");
            if ((proc_ren || proc_wen) && !proc_stall) begin
                if (proc_q.size() == 0) flag("unexpected_proc_completion");
                else begin
                    pe = proc_q.pop_front();
                    chk("proc_kind", {127'd0, proc_ren && !proc_wen}, {127'd0, pe.is_rd});
                    chk("proc_rdata", {96'd0, proc_rdata}, {96'd0, pe.rdata});
                end
            end
            if (mem_write && !prev_mw) begin
                if (mem_q.size() == 0) flag("unexpected_mem_write");
                else begin
                    me = mem_q.pop_front();
                    chk("mem_kind_wr", {127'd0, me.is_wr}, 128'd1);
                    chk("mem_wr_addr", {100'd0, mem_addr}, {100'd0, me.addr});
                    chk("mem_wdata", mem_wdata, me.wdata);
                end
            end
            if (mem_read && !prev_mr) begin
                if (mem_q.size() == 0) flag("unexpected_mem_read");
                else begin
                    me = mem_q.pop_front();
                    chk("mem_kind_rd", {127'd0, me.is_wr}, 128'd0);
                    chk("mem_rd_addr", {100'd0, mem_addr}, {100'd0, me.addr});
                end
            end
        end
        prev_mr = mem_read;
        prev_mw = mem_write;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit r, input bit w, input logic [29:0] a, input logic [31:0] d);
        proc_ren   = r;
        proc_wen   = w;
        proc_addr  = a;
        proc_wdata = d;
    endtask

    // Request must complete in this cycle with no memory traffic.
    task automatic hit_cycle(input string name);
        @(negedge clk);
        chk({name, "_stall"}, {127'd0, proc_stall}, 128'd0);
        chk({name, "_nomem"}, {126'd0, mem_read, mem_write}, 128'd0);
        tick();
        proc_ren = 1'b0;
        proc_wen = 1'b0;
    endtask

    task automatic mem_service(input logic [127:0] data);
        int n = 0;
        @(negedge clk);
        while (!(mem_read || mem_write) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            flag("mem_request_timeout");
            return;
        end
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; proc_ren = 1'b0; proc_wen = 1'b0; proc_addr = '0; proc_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {127'd0, proc_stall}, 128'd0);
        chk("rst_mem", {126'd0, mem_read, mem_write}, 128'd0);
        chk("rst_rdata", {96'd0, proc_rdata}, 128'd0);

        // Cold read at 0x10: miss, refill, hit one cycle after the fill edge.
        mem_q.push_back('{1'b0, 28'h0000004, 128'd0});
        proc_q.push_back('{1'b1, 32'hDEADBEEF});
        tick();
        issue(1, 0, 30'h0000010, 32'd0);
        @(negedge clk);
        chk("cold_stall", {127'd0, proc_stall}, 128'd1);
        chk("cold_rd_not_yet", {127'd0, mem_read}, 128'd0);
        @(negedge clk);
        chk("cold_mem_read", {127'd0, mem_read}, 128'd1);
        chk("cold_mem_addr", {100'd0, mem_addr}, 128'h4);
        mem_service(F0);
        hit_cycle("cold_done");

        // Write hit then read hit at 0x11 (word 1 of line 4).
        proc_q.push_back('{1'b0, 32'd0});
        issue(0, 1, 30'h0000011, 32'h12345678);
        hit_cycle("wr_hit");
        proc_q.push_back('{1'b1, 32'h12345678});
        issue(1, 0, 30'h0000011, 32'd0);
        hit_cycle("rd_hit");

        // Dirty eviction: read 0x30 (index 4, tag 1) evicts tag 0.
        mem_q.push_back('{1'b1, 28'h0000004, VIC});
        mem_q.push_back('{1'b0, 28'h000000C, 128'd0});
        proc_q.push_back('{1'b1, 32'hCAFEF00D});
        issue(1, 0, 30'h0000030, 32'd0);
        @(negedge clk);
        chk("evict_stall", {127'd0, proc_stall}, 128'd1);
        mem_service(128'd0);
        mem_service(F2);
        hit_cycle("evict_done");

        // Clean miss: read 0x10 replaces the clean tag-1 line, no writeback.
        mem_q.push_back('{1'b0, 28'h0000004, 128'd0});
        proc_q.push_back('{1'b1, 32'h0BADF00D});
        issue(1, 0, 30'h0000010, 32'd0);
        @(negedge clk);
        chk("clean_stall", {127'd0, proc_stall}, 128'd1);
        chk("clean_idle_mem", {126'd0, mem_read, mem_write}, 128'd0);
        @(negedge clk);
        chk("clean_mem", {126'd0, mem_read, mem_write}, 128'd2);
        mem_service(F3);
        hit_cycle("clean_done");
        proc_q.push_back('{1'b1, 32'h77777777});
        issue(1, 0, 30'h0000013, 32'd0);
        hit_cycle("offset3_hit");

        // Both requests high: write wins, read data stays zero.
        proc_q.push_back('{1'b0, 32'd0});
        issue(1, 1, 30'h0000012, 32'hA5A5A5A5);
        hit_cycle("wr_prio");
        proc_q.push_back('{1'b1, 32'hA5A5A5A5});
        issue(1, 0, 30'h0000012, 32'd0);
        hit_cycle("wr_prio_rd");

        // Reset during ALLOCATE with a coincident mem_ready.
        mem_q.push_back('{1'b0, 28'h0000012, 128'd0});
        issue(1, 0, 30'h0000048, 32'd0);
        @(negedge clk);
        chk("rstalloc_stall", {127'd0, proc_stall}, 128'd1);
        @(negedge clk);
        chk("rstalloc_mem_read", {127'd0, mem_read}, 128'd1);
        tick();
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = FX; proc_ren = 1'b0;
        tick();
        rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("rstalloc_idle_stall", {127'd0, proc_stall}, 128'd0);
        chk("rstalloc_idle_mem", {126'd0, mem_read, mem_write}, 128'd0);
        mem_q.push_back('{1'b0, 28'h0000012, 128'd0});
        proc_q.push_back('{1'b1, 32'h0000FACE});
        tick();
        issue(1, 0, 30'h0000048, 32'd0);
        @(negedge clk);
        chk("rstalloc_remiss", {127'd0, proc_stall}, 128'd1);
        mem_service(FY);
        hit_cycle("rstalloc_done");

`ifdef DCACHE_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("cnt_rst_hit", {96'd0, hit_cnt}, 128'd0);
        chk("cnt_rst_miss", {96'd0, miss_cnt}, 128'd0);
        mem_q.push_back('{1'b0, 28'h0000022, 128'd0});
        proc_q.push_back('{1'b1, 32'hFEEDC0DE});
        tick();
        issue(1, 0, 30'h0000088, 32'd0);
        mem_service(FP);
        hit_cycle("cnt_miss");
        proc_q.push_back('{1'b0, 32'd0});
        issue(0, 1, 30'h0000089, 32'h00000001);
        hit_cycle("cnt_wr");
        proc_q.push_back('{1'b1, 32'h00000001});
        issue(1, 0, 30'h0000089, 32'd0);
        hit_cycle("cnt_rd");
        @(negedge clk);
        chk("cnt_miss_val", {96'd0, miss_cnt}, 128'd1);
        chk("cnt_hit_val", {96'd0, hit_cnt}, 128'd3);
`endif

        tick(); tick(); tick();
        chk("proc_q_drained", 128'(proc_q.size()), 128'd0);
        chk("mem_q_drained", 128'(mem_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
